// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: adds one D-bit digit per clock, LSB digit first,
// with add/subtract/accumulate modes and a start/busy/done handshake.
module digit_serial_addsub #(
    parameter int N = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    input  logic         acc,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         busy,
    output logic         done
);

    localparam int K  = N / D;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state_q;
    logic [N-1:0]   opa_q;
    logic [N-1:0]   opb_q;
    logic [N-1:0]   sum_q;
    logic           carry_q;
    logic [CW-1:0]  k_q;
    logic [N-1:0]   s_q;
    logic           cout_q;
    logic           ovf_q;
    logic           busy_q;
    logic           done_q;

    logic [D-1:0]   dig_a;
    logic [D-1:0]   dig_b;
    logic [D:0]     dig_full;
    logic [D-1:0]   dig_sum;
    logic           dig_cout;
    logic [N-1:0]   sum_d;
    logic           last_digit;
    logic           ovf_d;

    // One digit slice of the ripple adder; the working sum is rebuilt with the
    // current digit merged so the final result can be loaded in the same cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sum_d           = sum_q;
        dig_a           = opa_q[k_q * D +: D];
        dig_b           = opb_q[k_q * D +: D];
        dig_full        = {1'b0, dig_a} + {1'b0, dig_b} + {{D{1'b0}}, carry_q};
        dig_sum         = dig_full[D-1:0];
        dig_cout        = dig_full[D];
        sum_d[k_q * D +: D] = dig_sum;
        last_digit      = (k_q == CW'(K - 1));
        // Same-sign operands yielding a different-sign MSB equals carry-in XOR carry-out of bit N-1.
        ovf_d           = (dig_a[D-1] == dig_b[D-1]) && (dig_sum[D-1] != dig_a[D-1]);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        opa_q   <= acc ? s_q : a;
                        opb_q   <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        k_q     <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= dig_cout;
                    k_q     <= k_q + CW'(1);
                    if (last_digit) begin
                        s_q     <= sum_d;
                        cout_q  <= dig_cout;
                        ovf_q   <= ovf_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
- Parametrised multi-cycle adder/subtractor that processes operands one D-bit digit per clock, LSB digit first.
- Generalises the lab's combinational ripple adder in four ways: any width, a selectable digit size, a subtract mode, and an accumulate mode that reuses the previous result as operand A.
- Uses a start/busy/done handshake.
- Sits between switch/register inputs and display logic in DE1 datapath exercises.

Parameters:
- N, 16, operand and result width in bits; N must be an integer multiple of D.
- D, 4, digit width processed per cycle; the number of digit cycles is K = N/D.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- a  in  N  operand A; ignored when acc=1.
- b  in  N  operand B.
- cin  in  1  carry-in for add; ignored when sub=1.
- sub  in  1  0 = add, 1 = subtract (A - B).
- acc  in  1  1 = operand A taken from the current s register.
- s  out  N  result register; holds the last completed result.
- cout  out  1  carry out of the MSB; for subtract, 1 = no borrow (A >= B unsigned).
- ovf  out  1  two's-complement overflow of the last result.
- busy  out  1  high while digits are being processed (RUN).
- done  out  1  one-cycle pulse when s/cout/ovf are updated.

Behaviour:
- Reset (synchronous, active-high) forces: state=IDLE, s=0, cout=0, ovf=0, busy=0, done=0, working registers cleared.
- Reset has priority over every other input, including mid-RUN.
- An operation in flight when reset is applied is discarded; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at a clock edge, capture into working registers:
    - opA = acc ? s : a
    - opB = sub ? ~b : b
    - carry = sub ? 1 : cin
    - digit counter = 0
  - Go to RUN.
  - If start=0, stay in IDLE.
- RUN:
  - busy=1.
  - Each cycle, add digit k of opA, digit k of opB and the carry.
  - Store the D-bit sum into digit k of the working sum; the carry-out becomes the next carry.
  - Increment k.
  - On the cycle processing k = K-1:
    - Load s from the working sum, with the final digit merged.
    - cout = final carry.
    - ovf = (carry into bit N-1) XOR (carry out of bit N-1).
    - Go to DONE.
- DONE: done=1, busy=0, then unconditionally go to IDLE on the next edge.
- start is ignored in RUN and in DONE; it is not queued.
- Timing, with start=1 sampled at the edge ending cycle t:
  - busy=1 in cycles t+1 .. t+K.
  - done=1 and the new s/cout/ovf are visible in cycle t+K+1.
  - The earliest next accepted start is sampled in cycle t+K+2.
- s, cout and ovf change only at result load or reset; partial sums are never visible on s.
- Changes on a, b, cin, sub or acc after capture have no effect on the operation in flight.
- Arithmetic is modulo 2^N; the carry out of the MSB goes only to cout.
- Subtract of B=0 gives s=A, cout=1.
- K=1 (D=N): single RUN cycle, so done appears in cycle t+2.

Test Plan:
1. Default parameters (N=16, D=4, K=4). Add: a=0x1234, b=0x4321, cin=0, sub=0, start pulse → busy high 4 cycles; in cycle t+5 done=1, s=0x5555, cout=0, ovf=0.
2. Add carry/overflow boundaries:
   - 0xFFFF+0x0001 → s=0x0000, cout=1, ovf=0.
   - 0x7FFF+0x0001 → s=0x8000, cout=0, ovf=1.
   - 0xFFFF+0x0000 with cin=1 → s=0x0000, cout=1.
3. Subtract:
   - 0x0005-0x0007 → s=0xFFFE, cout=0, ovf=0.
   - 0x8000-0x0001 → s=0x7FFF, cout=1, ovf=1.
   - 0x1234-0x1234 → s=0x0000, cout=1.
4. Accumulate: add 0x0003+0x0000 → s=0x0003. Then acc=1, b=0x0004, a=0xAAAA → s=0x0007. Then acc=1, sub=1, b=0x0008 → s=0xFFFF, cout=0.
5. Handshake robustness:
   - Start re-asserted during RUN and DONE → ignored, exactly one done pulse.
   - a/b changed mid-RUN → result unaffected.
   - s holds the old value until done.
6. Reset and parameter sweep:
   - Reset asserted in the 2nd RUN cycle → next cycle busy=0, s=0, cout=0, ovf=0, and no done pulse follows.
   - Rerun scenario 1 with D=16 (done at t+2) and D=1 (done at t+17), same results.
